// File: rtl/ddr4_ddr3_cmd_xlate_if.sv
// DDR4 command pins in; DDR3 command pins, MR shadow readback and bank/error status out.
interface ddr4_ddr3_cmd_xlate_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              ddr4_cke;
    logic              ddr4_cs_n;
    logic              ddr4_act_n;
    logic [16:0]       ddr4_adr;
    logic [1:0]        ddr4_ba;
    logic [1:0]        ddr4_bg;
    logic              ddr3_cke;
    logic              ddr3_cs_n;
    logic              ddr3_ras_n;
    logic              ddr3_cas_n;
    logic              ddr3_we_n;
    logic [2:0]        ddr3_ba;
    logic [ADDR_W-1:0] ddr3_adr;
    logic [1:0]        mr_sel;
    logic [15:0]       mr_data;
    logic [7:0]        bank_open;
    logic              proto_err;
    logic [1:0]        err_code;
    logic [CNT_W-1:0]  cmd_cnt;

    modport master (
        output ddr4_cke, ddr4_cs_n, ddr4_act_n, ddr4_adr, ddr4_ba, ddr4_bg, mr_sel,
        input  ddr3_cke, ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n, ddr3_ba, ddr3_adr,
        input  mr_data, bank_open, proto_err, err_code, cmd_cnt
    );
    modport slave (
        input  ddr4_cke, ddr4_cs_n, ddr4_act_n, ddr4_adr, ddr4_ba, ddr4_bg, mr_sel,
        output ddr3_cke, ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n, ddr3_ba, ddr3_adr,
        output mr_data, bank_open, proto_err, err_code, cmd_cnt
    );
endinterface

// File: rtl/ddr4_ddr3_cmd_xlate.sv
// DDR4 -> DDR3 command translator with MR0-3 shadows and saturating command counter.
// Define XLATE_BANK_TRACK_EN to add bank-open tracking and protocol error flagging.
module ddr4_ddr3_cmd_xlate #(
    parameter int ADDR_W = 16,
    parameter int PIPE   = 1,
    parameter int CNT_W  = 16
) (
    input logic                  ddr4_ck_t,
    input logic                  ddr4_reset_n,
    ddr4_ddr3_cmd_xlate_if.slave bus
);
    localparam logic [2:0] K_NONE = 3'd0, K_ACT = 3'd1, K_PRE = 3'd2, K_RD = 3'd3,
                           K_WR   = 3'd4, K_MRS = 3'd5, K_REF = 3'd6, K_ZQ = 3'd7;

    typedef struct packed {
        logic              cke;
        logic              cs_n;
        logic [2:0]        rcw;
        logic [2:0]        ba;
        logic [ADDR_W-1:0] adr;
        logic [2:0]        kind;
    } cmd_t;

    localparam cmd_t CMD_IDLE = '{cke: 1'b0, cs_n: 1'b1, rcw: 3'b111, ba: 3'b000,
                                  adr: '0, kind: K_NONE};

    cmd_t        dec;
    logic [15:0] mr_val;

    always_comb begin
        mr_val        = bus.ddr4_adr[15:0];
        mr_val[15:13] = 3'b000;
        if (bus.ddr4_ba == 2'd0) begin
            mr_val[12] = 1'b0;
            mr_val[8]  = 1'b1;
        end
        if (bus.ddr4_ba == 2'd1) mr_val[0] = 1'b1;

        dec.cke  = bus.ddr4_cke;
        dec.cs_n = bus.ddr4_cs_n;
        dec.rcw  = bus.ddr4_adr[16:14];
        dec.ba   = {bus.ddr4_bg[0], bus.ddr4_ba};
        dec.adr  = bus.ddr4_adr[ADDR_W-1:0];
        dec.kind = K_NONE;
        if (bus.ddr4_cs_n) begin
            dec.rcw = 3'b111;
        end else if (!bus.ddr4_act_n) begin
            dec.rcw  = 3'b011;
            dec.kind = K_ACT;
        end else begin
            case (bus.ddr4_adr[16:14])
                3'b000: begin
                    // MR4-MR7 have no DDR3 counterpart: swallow as a NOP
                    if (bus.ddr4_bg[0]) begin
                        dec.rcw = 3'b111;
                    end else begin
                        dec.kind = K_MRS;
                        dec.ba   = {1'b0, bus.ddr4_ba};
                        dec.adr  = mr_val[ADDR_W-1:0];
                    end
                end
                3'b001:  dec.kind = K_REF;
                3'b010:  dec.kind = K_PRE;
                3'b100:  dec.kind = K_WR;
                3'b101:  dec.kind = K_RD;
                3'b110:  dec.kind = K_ZQ;
                default: dec.rcw  = 3'b111;
            endcase
        end
    end

    cmd_t pipe_q [PIPE];
    cmd_t emit;

    always_ff @(posedge ddr4_ck_t or negedge ddr4_reset_n) begin
        if (!ddr4_reset_n) begin
            for (int i = 0; i < PIPE; i++) pipe_q[i] <= CMD_IDLE;
        end else begin
            pipe_q[0] <= dec;
            for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // emit is the command being loaded into the output stage this edge
    generate
        if (PIPE == 1) begin : g_emit1
            assign emit = dec;
        end else begin : g_emitn
            assign emit = pipe_q[PIPE-2];
        end
    endgenerate

    assign bus.ddr3_cke   = pipe_q[PIPE-1].cke;
    assign bus.ddr3_cs_n  = pipe_q[PIPE-1].cs_n;
    assign bus.ddr3_ras_n = pipe_q[PIPE-1].rcw[2];
    assign bus.ddr3_cas_n = pipe_q[PIPE-1].rcw[1];
    assign bus.ddr3_we_n  = pipe_q[PIPE-1].rcw[0];
    assign bus.ddr3_ba    = pipe_q[PIPE-1].ba;
    assign bus.ddr3_adr   = pipe_q[PIPE-1].adr;

    logic [ADDR_W-1:0] shadow [4];
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge ddr4_ck_t or negedge ddr4_reset_n) begin
        if (!ddr4_reset_n) begin
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
            cnt_q <= '0;
        end else begin
            if (emit.kind == K_MRS) shadow[emit.ba[1:0]] <= emit.adr;
            if (emit.kind != K_NONE && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.mr_data             = '0;
        bus.mr_data[ADDR_W-1:0] = shadow[bus.mr_sel];
    end
    assign bus.cmd_cnt = cnt_q;

`ifdef XLATE_BANK_TRACK_EN
    logic [7:0] open_q;
    logic       err_q;
    logic [1:0] code_q;
    logic [1:0] err_now;

    always_comb begin
        err_now = 2'b00;
        case (emit.kind)
            K_ACT:        if (open_q[emit.ba])  err_now = 2'b01;
            K_RD, K_WR:   if (!open_q[emit.ba]) err_now = 2'b10;
            K_MRS, K_REF: if (|open_q)          err_now = 2'b11;
            default: ;
        endcase
    end

    always_ff @(posedge ddr4_ck_t or negedge ddr4_reset_n) begin
        if (!ddr4_reset_n) begin
            open_q <= '0;
            err_q  <= 1'b0;
            code_q <= 2'b00;
        end else begin
            case (emit.kind)
                K_ACT: open_q[emit.ba] <= 1'b1;
                K_PRE: if (emit.adr[10]) open_q <= '0;
                       else open_q[emit.ba] <= 1'b0;
                K_RD, K_WR: if (emit.adr[10]) open_q[emit.ba] <= 1'b0;
                default: ;
            endcase
            // first error wins; the command itself is still forwarded
            if (!err_q && err_now != 2'b00) begin
                err_q  <= 1'b1;
                code_q <= err_now;
            end
        end
    end

    assign bus.bank_open = open_q;
    assign bus.proto_err = err_q;
    assign bus.err_code  = code_q;
`else
    assign bus.bank_open = '0;
    assign bus.proto_err = 1'b0;
    assign bus.err_code  = 2'b00;
`endif
endmodule

// File: tb/tb_ddr4_ddr3_cmd_xlate.sv
// Scoreboard bench: PIPE=1/CNT_W=16 and PIPE=2/CNT_W=4 instances fed the same DDR4 stream.
module tb_ddr4_ddr3_cmd_xlate;
`ifdef XLATE_BANK_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]       ctl;
        logic [2:0]       ba;
        logic [15:0]      adr;
        logic             chk_adr;
        logic [3:0][15:0] shd;
        logic [7:0]       bank;
        logic             perr;
        logic [1:0]       code;
        logic [15:0]      cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddr4_ddr3_cmd_xlate_if #(.ADDR_W(16), .CNT_W(16)) ifa ();
    ddr4_ddr3_cmd_xlate_if #(.ADDR_W(16), .CNT_W(4))  ifb ();

    ddr4_ddr3_cmd_xlate #(.ADDR_W(16), .PIPE(1), .CNT_W(16)) dut_a (
        .ddr4_ck_t(clk), .ddr4_reset_n(rst_n), .bus(ifa));
    ddr4_ddr3_cmd_xlate #(.ADDR_W(16), .PIPE(2), .CNT_W(4)) dut_b (
        .ddr4_ck_t(clk), .ddr4_reset_n(rst_n), .bus(ifb));

    int checks = 0;
    int errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t rst_exp;
    logic [1:0] sel_rot = 2'd0;

    logic [3:0][15:0] m_shd;
    logic [7:0]       m_bank;
    logic             m_perr;
    logic [1:0]       m_code;
    logic [15:0]      m_cnt_a, m_cnt_b;

    task automatic check(input string tag, input string fld, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [4:0] ctl,
                       input logic [2:0] ba, input logic [15:0] adr, input logic [15:0] mrd,
                       input logic [1:0] sel, input logic [7:0] bank, input logic perr,
                       input logic [1:0] code, input logic [15:0] cnt);
        check(tag, "ctl", 32'(ctl), 32'(e.ctl));
        if (e.chk_adr) begin
            check(tag, "ba", 32'(ba), 32'(e.ba));
            check(tag, "adr", 32'(adr), 32'(e.adr));
        end
        check(tag, "mr_data", 32'(mrd), 32'(e.shd[sel]));
        check(tag, "bank_open", 32'(bank), 32'(e.bank));
        check(tag, "proto_err", 32'(perr), 32'(e.perr));
        check(tag, "err_code", 32'(code), 32'(e.code));
        check(tag, "cmd_cnt", 32'(cnt), 32'(e.cnt));
    endtask

    task automatic cmp_a(input string tag, input exp_t e);
        cmp(tag, e, {ifa.ddr3_cke, ifa.ddr3_cs_n, ifa.ddr3_ras_n, ifa.ddr3_cas_n, ifa.ddr3_we_n},
            ifa.ddr3_ba, ifa.ddr3_adr, ifa.mr_data, ifa.mr_sel, ifa.bank_open, ifa.proto_err,
            ifa.err_code, ifa.cmd_cnt);
    endtask

    task automatic cmp_b(input string tag, input exp_t e);
        cmp(tag, e, {ifb.ddr3_cke, ifb.ddr3_cs_n, ifb.ddr3_ras_n, ifb.ddr3_cas_n, ifb.ddr3_we_n},
            ifb.ddr3_ba, ifb.ddr3_adr, ifb.mr_data, ifb.mr_sel, ifb.bank_open, ifb.proto_err,
            ifb.err_code, {12'h000, ifb.cmd_cnt});
    endtask

    task automatic drive(input logic cke, input logic cs_n, input logic act_n,
                         input logic [1:0] bg, input logic [1:0] ba, input logic [16:0] adr);
        ifa.ddr4_cke = cke;  ifa.ddr4_cs_n = cs_n; ifa.ddr4_act_n = act_n;
        ifa.ddr4_bg  = bg;   ifa.ddr4_ba   = ba;   ifa.ddr4_adr   = adr;
        ifb.ddr4_cke = cke;  ifb.ddr4_cs_n = cs_n; ifb.ddr4_act_n = act_n;
        ifb.ddr4_bg  = bg;   ifb.ddr4_ba   = ba;   ifb.ddr4_adr   = adr;
        ifa.mr_sel = sel_rot;
        ifb.mr_sel = sel_rot;
    endtask

    task automatic model_reset();
        m_shd = '0; m_bank = '0; m_perr = 1'b0; m_code = 2'b00;
        m_cnt_a = '0; m_cnt_b = '0;
    endtask

    task automatic count();
        if (m_cnt_a != 16'hFFFF) m_cnt_a++;
        if (m_cnt_b != 16'd15) m_cnt_b++;
    endtask

    // k: 1=ACT 2=PRE 3=RD/WR 4=MRS/REF
    task automatic track(input int k, input logic [2:0] b, input logic a10);
        logic [1:0] c;
        c = 2'b00;
        if (TRACK) begin
            case (k)
                1: begin if (m_bank[b]) c = 2'b01; m_bank[b] = 1'b1; end
                2: if (a10) m_bank = '0; else m_bank[b] = 1'b0;
                3: begin if (!m_bank[b]) c = 2'b10; if (a10) m_bank[b] = 1'b0; end
                default: if (|m_bank) c = 2'b11;
            endcase
            if (!m_perr && c != 2'b00) begin m_perr = 1'b1; m_code = c; end
        end
    endtask

    task automatic issue(input logic cke, input logic cs_n, input logic act_n,
                         input logic [1:0] bg, input logic [1:0] ba, input logic [16:0] adr);
        exp_t e;
        logic [15:0] mv;
        @(negedge clk);
        drive(cke, cs_n, act_n, bg, ba, adr);
        sel_rot++;
        e = '0;
        e.ctl = {cke, 4'b1111};
        e.ba  = {bg[0], ba};
        e.adr = adr[15:0];
        if (!cs_n) begin
            e.ctl = {cke, 4'b0111};
            if (!act_n) begin
                e.ctl = {cke, 4'b0011}; e.chk_adr = 1'b1;
                track(1, {bg[0], ba}, adr[10]); count();
            end else begin
                case (adr[16:14])
                    3'b000: if (!bg[0]) begin
                        mv = adr[15:0]; mv[15:13] = 3'b000;
                        if (ba == 2'd0) begin mv[12] = 1'b0; mv[8] = 1'b1; end
                        if (ba == 2'd1) mv[0] = 1'b1;
                        e.ctl = {cke, 4'b0000}; e.ba = {1'b0, ba}; e.adr = mv; e.chk_adr = 1'b1;
                        m_shd[ba] = mv;
                        track(4, 3'd0, 1'b0); count();
                    end
                    3'b011, 3'b111: ;
                    default: begin
                        e.ctl = {cke, 1'b0, adr[16:14]}; e.chk_adr = 1'b1;
                        count();
                        if (adr[16:14] == 3'b001) track(4, 3'd0, 1'b0);
                        else if (adr[16:14] == 3'b010) track(2, {bg[0], ba}, adr[10]);
                        else if (adr[16:14] != 3'b110) track(3, {bg[0], ba}, adr[10]);
                    end
                endcase
            end
        end
        e.shd = m_shd; e.bank = m_bank; e.perr = m_perr; e.code = m_code;
        e.cnt = m_cnt_a; qa.push_back(e);
        e.cnt = m_cnt_b; qb.push_back(e);
        @(posedge clk); #1;
        cmp_a("A", qa.pop_front());
        if (qb.size() > 1) cmp_b("B", qb.pop_front());
    endtask

    task automatic act(input logic [2:0] b);
        issue(1'b1, 1'b0, 1'b0, {1'b0, b[2]}, b[1:0], 17'h1_2345);
    endtask
    task automatic rw(input logic rd, input logic [2:0] b, input logic a10);
        logic [16:0] a;
        a = {rd ? 3'b101 : 3'b100, 14'h0018}; a[10] = a10;
        issue(1'b1, 1'b0, 1'b1, {1'b0, b[2]}, b[1:0], a);
    endtask
    task automatic pre(input logic [2:0] b, input logic a10);
        logic [16:0] a;
        a = {3'b010, 14'h0000}; a[10] = a10;
        issue(1'b1, 1'b0, 1'b1, {1'b0, b[2]}, b[1:0], a);
    endtask
    task automatic mrs(input logic bg0, input logic [1:0] ba, input logic [15:0] v);
        issue(1'b1, 1'b0, 1'b1, {1'b0, bg0}, ba, {1'b0, v});
    endtask
    task automatic simple(input logic [2:0] rcw);
        issue(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, {rcw, 14'h0400});
    endtask

    task automatic reset_release();
        drive(1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 17'h0);
        qa.delete(); qb.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        qb.push_back(rst_exp);
    endtask

    initial begin
        rst_exp = '0;
        rst_exp.ctl = 5'b01111;
        rst_exp.chk_adr = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 17'h0);
        model_reset();
        #12;
        cmp_a("A.rst", rst_exp);
        cmp_b("B.rst", rst_exp);
        reset_release();

        mrs(1'b0, 2'd0, 16'h0000);
        mrs(1'b0, 2'd1, 16'h25A2);
        mrs(1'b0, 2'd2, 16'h1234);
        mrs(1'b0, 2'd3, 16'h3FFF);
        mrs(1'b1, 2'd2, 16'h0ABC);
        issue(1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 17'h0);
        issue(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 17'h1_C000);

        act(3'd6); rw(1'b1, 3'd6, 1'b0);
        act(3'd0); act(3'd7); pre(3'd0, 1'b1);
        mrs(1'b0, 2'd2, 16'h0040);

        act(3'd3); act(3'd3);
        rw(1'b1, 3'd5, 1'b0);
        rw(1'b0, 3'd3, 1'b1);
        pre(3'd0, 1'b0);
        simple(3'b110);
        simple(3'b011);
        simple(3'b111);
        issue(1'b1, 1'b0, 1'b1, 2'b01, 2'b11, 17'h0_0000 | {3'b111, 14'h0});

        for (int i = 0; i < 20; i++) simple(3'b001);

        act(3'd1); simple(3'b001);
        #2 rst_n = 1'b0;
        #1;
        cmp_a("A.midrst", rst_exp);
        cmp_b("B.midrst", rst_exp);
        reset_release();

        act(3'd1);
        rw(1'b1, 3'd1, 1'b1);
        simple(3'b001);
        issue(1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 17'h0);
        issue(1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 17'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr4_ddr3_cmd_xlate.md
DDR4_DDR3_CMD_XLATE -- requirements
Module: ddr4_ddr3_cmd_xlate

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, the DDR3 address width (14..16).
REQ-002 The block SHALL have parameter PIPE, default 1, the command pipeline depth in cycles (1 or 2).
REQ-003 The block SHALL have parameter CNT_W, default 16, the width of the command counter.
REQ-004 The block SHALL have ports ddr4_ck_t in 1, the sole clock (rising edge); ddr4_reset_n in 1, the reset, asynchronous, active-low.
REQ-005 The block SHALL have ports ddr4_cke, ddr4_cs_n and ddr4_act_n, each in 1, the DDR4 command pins.
REQ-006 The block SHALL have ports ddr4_adr in 17, where A16/A15/A14 are RAS_n/CAS_n/WE_n when ACT_n=1; ddr4_ba in 2; ddr4_bg in 2.
REQ-007 The block SHALL have ports ddr3_cke, ddr3_cs_n, ddr3_ras_n, ddr3_cas_n and ddr3_we_n, each out 1, registered.
REQ-008 The block SHALL have ports ddr3_ba out 3 and ddr3_adr out ADDR_W, both registered.
REQ-009 The block SHALL have ports mr_sel in 2, the shadow readback select, and mr_data out 16, the shadow MR contents (combinational from the shadow registers).
REQ-010 The block SHALL have ports bank_open out 8, one bit per DDR3 bank; proto_err out 1, sticky; err_code out 2; cmd_cnt out CNT_W.

Function
REQ-011 Decode SHALL be qualified by cs_n=0: act_n=0 is ACT; otherwise {A16,A15,A14} gives 000 MRS, 001 REF, 010 PRE, 100 WR, 101 RD, 110 ZQ, 111 NOP, and 011 is treated as NOP.
REQ-012 cs_n=1 SHALL produce a DDR3 deselect (cs_n=1, ras/cas/we=111).
REQ-013 The DDR3 bank SHALL be {bg[0],ba[1:0]} for all non-MRS commands.
REQ-014 The DDR3 address SHALL be ddr4_adr[ADDR_W-1:0] for non-MRS commands.
REQ-015 ACT SHALL drive DDR3 ras/cas/we = 011.
REQ-016 All other commands SHALL drive DDR3 ras/cas/we = ddr4_adr[16:14].
REQ-017 An MRS with bg[0]=0 (MR0-MR3) SHALL emit a DDR3 MRS with ba={0,ba[1:0]} and A[15:13]=0.
REQ-018 For MR0, that MRS SHALL force A12=0 and A8=1; for MR1 it SHALL force A0=1; all other bits SHALL pass through.
REQ-019 An MRS with bg[0]=1 (MR4-MR7) SHALL be suppressed: it emits a DDR3 NOP (cs_n=0, ras/cas/we=111), no shadow update and no count.
REQ-020 Every emitted MR0-MR3 value SHALL be written into shadow[ba], and mr_data SHALL equal shadow[mr_sel] zero-extended to 16 bits.
REQ-021 Latency SHALL be exactly PIPE cycles from a DDR4 input edge to the DDR3 outputs, with all DDR3 outputs moving together.
REQ-022 ddr3_cke SHALL be delayed by the same PIPE cycles.
REQ-023 Bank tracking SHALL update on the cycle the command is emitted.
REQ-024 ACT SHALL set bank_open[bank].
REQ-025 PRE with A10=1 SHALL clear all eight bits of bank_open.
REQ-026 PRE with A10=0 SHALL clear bank_open[bank].
REQ-027 RD/WR with A10=1 (auto-precharge) SHALL clear bank_open[bank].
REQ-028 Error detection SHALL use err_code 01 for ACT to an open bank and 10 for RD/WR to a closed bank.
REQ-029 Error detection SHALL use err_code 11 for MRS or REF while any bank is open.
REQ-030 On the first error, proto_err SHALL set and err_code SHALL latch; later errors SHALL not change err_code.
REQ-031 An erroring command SHALL still be forwarded unchanged.
REQ-032 cmd_cnt SHALL increment on each emitted ACT/PRE/RD/WR/MRS/REF/ZQ and saturate at all-ones, with no wrap.
REQ-033 ACT to an already-open bank SHALL leave the bit set and flag error 01.

Reset
REQ-034 While ddr4_reset_n=0, all outputs SHALL be driven asynchronously as follows: ddr3_cke=0, ddr3_cs_n=1, ras/cas/we=111, ba=0 and adr=0.
REQ-035 While ddr4_reset_n=0, bank_open=0, proto_err=0, err_code=0, cmd_cnt=0, all shadows=0 and pipeline contents=deselect.
REQ-036 Reset asserted mid-pipeline SHALL discard in-flight commands.
REQ-037 The first command after deassertion SHALL appear PIPE cycles after it is sampled.

Configuration
REQ-038 With macro XLATE_BANK_TRACK_EN defined, REQ-023..REQ-033 (bank_open, proto_err, err_code) SHALL be implemented.
REQ-039 Without XLATE_BANK_TRACK_EN, bank_open=0, proto_err=0 and err_code=0 constantly, and command forwarding, shadows and cmd_cnt SHALL be unchanged.

Verification
REQ-040 MRS to MR0 with adr=0x0000 SHALL produce, PIPE cycles later, DDR3 ras/cas/we=000, ba=000, adr=0x0100, and mr_data(mr_sel=0)=0x0100.
REQ-041 ACT with bg=01, ba=10 followed by RD with A10=0 to the same bank SHALL give bank_open=0x40, no error, and cmd_cnt=2.
REQ-042 ACT to bank 3 twice SHALL set proto_err=1 and err_code=01; a subsequent RD to closed bank 5 SHALL leave err_code at 01.
REQ-043 ACT to banks 0 and 7 followed by PRE with A10=1 SHALL give bank_open=0x00; a following MRS SHALL raise no error.
REQ-044 MRS with bg[0]=1 SHALL produce a DDR3 NOP with shadows and cmd_cnt unchanged.
REQ-045 With CNT_W=4, 20 REF commands issued with no bank open SHALL leave cmd_cnt=15; reset asserted mid-stream SHALL give all outputs their reset values immediately.
